// File: rtl/tts_pkg.sv
// tts_pkg: shared state enum and sizing constants for the truth table sweeper
package tts_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} tts_state_t;
  localparam int TTS_NUM_INPUTS = 7;
  localparam int TTS_NUM_VECTORS = 128;
  localparam int TTS_WEIGHT_W = 8;
endpackage

// File: rtl/tts_vector_counter.sv
// tts_vector_counter: vector index plus per-vector hold counter with sample strobes
module tts_vector_counter
  import tts_pkg::*;
#(
  parameter int SETTLE_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      en,
  output logic [TTS_NUM_INPUTS-1:0] idx,
  output logic                      sample_now,
  output logic                      last_sample
);
  logic [3:0] hold;
  assign sample_now = en && (hold == 4'(SETTLE_CYCLES));
  assign last_sample = sample_now && (idx == '1);
  // hold each index SETTLE_CYCLES+1 cycles, advancing on the sample cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      hold <= '0;
    end else if (clr) begin
      idx <= '0;
      hold <= '0;
    end else if (en) begin
      idx <= sample_now ? idx + 1'b1 : idx;
      hold <= sample_now ? '0 : hold + 1'b1;
    end
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all 128 inputs of a 7-input cell and captures its truth table (optional check: TRUTH_TABLE_SWEEPER_CHECK_EN)
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int SETTLE_CYCLES = 0
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
  , parameter logic [TTS_NUM_VECTORS-1:0] EXPECTED_TT = '0
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [TTS_NUM_INPUTS-1:0]  dut_x,
  input  logic                       dut_out,
  output logic [TTS_NUM_VECTORS-1:0] truth_table,
  output logic [TTS_WEIGHT_W-1:0]    weight
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
  , output logic                     match
`endif
);
  tts_state_t state, state_d;
  logic accept, sample_now, last_sample;
  logic [TTS_NUM_INPUTS-1:0] idx;
  logic [TTS_NUM_VECTORS-1:0] tt_nxt;
  assign accept = (state == IDLE) && start;
  tts_vector_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .clr(accept),
    .en(state == DRIVE),
    .idx(idx),
    .sample_now(sample_now),
    .last_sample(last_sample)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // next state and outputs; DONE always lasts a single cycle
  always_comb begin
    state_d = accept ? DRIVE :
              (state == DRIVE && last_sample) ? DONE :
              (state == DONE) ? IDLE : state;
    busy = state == DRIVE;
    done = state == DONE;
    dut_x = busy ? idx : '0;
  end
  // table with the current sample merged in, so the final compare sees bit 127
  always_comb begin
    tt_nxt = truth_table;
    tt_nxt[idx] = dut_out;
  end
  // capture register and one-count accumulator
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      truth_table <= '0;
      weight <= '0;
    end else if (accept) begin
      truth_table <= '0;
      weight <= '0;
    end else if (sample_now) begin
      truth_table <= tt_nxt;
      weight <= weight + {{(TTS_WEIGHT_W-1){1'b0}}, dut_out};
    end
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
  // signature compare registered at the final sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) match <= (EXPECTED_TT == '0);
    else if (accept) match <= (EXPECTED_TT == '0);
    else if (last_sample) match <= (tt_nxt == EXPECTED_TT);
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: randomized self-checking bench against a behavioural truth-table model
module tb_truth_table_sweeper;
  function automatic int pop7(logic [6:0] x);
    int n = 0;
    for (int i = 0; i < 7; i++) n += int'(x[i]);
    return n;
  endfunction
  function automatic int pop128(logic [127:0] x);
    int n = 0;
    for (int i = 0; i < 128; i++) n += int'(x[i]);
    return n;
  endfunction
  function automatic logic fval(int mode, logic [6:0] x, logic [127:0] r);
    case (mode)
      0: return 1'b0;
      1: return x[0];
      2: return &x;
      3: return pop7(x) >= 4;
      5: return (pop7(x) >= 4) ^ (x == 7'd5);
      default: return r[x];
    endcase
  endfunction
  function automatic logic [127:0] model_tt(int mode, logic [127:0] r);
    logic [127:0] t = '0;
    for (int i = 0; i < 128; i++) t[i] = fval(mode, 7'(i), r);
    return t;
  endfunction
  localparam logic [127:0] MAJ_TT = model_tt(3, '0);
  logic clk = 0, rst_n = 0, start0 = 0, start3 = 0, sel = 0;
  int fn = 0;
  logic [127:0] rnd_tt = '0;
  logic busy0, done0, busy3, done3, out0, out3;
  logic [6:0] dx0, dx3;
  logic [127:0] tt0, tt3;
  logic [7:0] w0, w3;
  int vectors = 0, fails = 0;
  always #5 clk = ~clk;
  assign out0 = fval(fn, dx0, rnd_tt);
  assign out3 = fval(fn, dx3, rnd_tt);
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
  logic m0, m3;
  wire m_s = sel ? m3 : m0;
`endif
  wire busy_s = sel ? busy3 : busy0;
  wire done_s = sel ? done3 : done0;
  wire [6:0] dx_s = sel ? dx3 : dx0;
  wire [127:0] tt_s = sel ? tt3 : tt0;
  wire [7:0] w_s = sel ? w3 : w0;
  truth_table_sweeper #(.SETTLE_CYCLES(0)
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    , .EXPECTED_TT(MAJ_TT)
`endif
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .dut_x(dx0), .dut_out(out0), .truth_table(tt0), .weight(w0)
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    , .match(m0)
`endif
  );
  truth_table_sweeper #(.SETTLE_CYCLES(3)
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    , .EXPECTED_TT(MAJ_TT)
`endif
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
    .dut_x(dx3), .dut_out(out3), .truth_table(tt3), .weight(w3)
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    , .match(m3)
`endif
  );
  task automatic check(string tag, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic set_start(logic v);
    if (sel) start3 = v;
    else start0 = v;
  endtask
  task automatic check_reset(string tag);
    check({tag, "_busy"}, busy_s, 0);
    check({tag, "_done"}, done_s, 0);
    check({tag, "_x"}, dx_s, 0);
    check({tag, "_tt"}, tt_s, 0);
    check({tag, "_w"}, w_s, 0);
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    check({tag, "_match"}, m_s, MAJ_TT == '0);
`endif
  endtask
  task automatic sweep(int mode, bit repulse);
    int s = sel ? 3 : 0;
    int cyc = 1, dones = 1, hold_bad = 0;
    logic [127:0] et;
    fn = mode;
    if (mode == 4) rnd_tt = {$urandom, $urandom, $urandom, $urandom};
    et = model_tt(mode, rnd_tt);
    @(negedge clk);
    set_start(1);
    @(negedge clk);
    set_start(0);
    check("busy_rise", busy_s, 1);
    check("x_first", dx_s, 0);
    while (!done_s && cyc < 2000) begin
      if (!busy_s || dx_s !== 7'((cyc - 1) / (s + 1))) hold_bad++;
      if (repulse && cyc == 60) set_start(1);
      if (repulse && cyc == 61) set_start(0);
      @(negedge clk);
      cyc++;
    end
    check("done_cycle", cyc, 1 + 128 * (s + 1));
    check("hold_pattern", hold_bad, 0);
    check("busy_at_done", busy_s, 0);
    check("tt", tt_s, et);
    check("weight", w_s, pop128(et));
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    if (mode == 3) check("match_hit", m_s, 1);
    if (mode == 5) check("match_miss", m_s, 0);
`endif
    if (repulse) set_start(1);
    @(negedge clk);
    set_start(0);
    repeat (6) begin
      if (done_s) dones++;
      if (busy_s) dones += 100;
      @(negedge clk);
    end
    check("single_done", dones, 1);
    check("tt_hold", tt_s, et);
    check("w_hold", w_s, pop128(et));
  endtask
  initial begin
    int n = 0, bad = 0;
    repeat (2) @(negedge clk);
    sel = 0;
    check_reset("rst0");
    sel = 1;
    check_reset("rst3");
    rst_n = 1;
    sel = 0;
    sweep(0, 0);
    sweep(1, 0);
    check("alt_pattern", tt_s, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    sweep(4, 0);
    sweep(4, 0);
    sweep(3, 0);
    check("maj_weight", w_s, 64);
    sweep(5, 0);
    sweep(1, 1);
    sel = 1;
    sweep(2, 0);
    check("and_tt", tt_s, {1'b1, 127'b0});
    sweep(4, 0);
    sel = 0;
    fn = 1;
    @(negedge clk);
    set_start(1);
    @(negedge clk);
    set_start(0);
    while (dx_s !== 7'd50 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_50", n < 500, 1);
    rst_n = 0;
    #1;
    check_reset("abort");
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (140) begin
      if (done_s || busy_s) bad++;
      @(negedge clk);
    end
    check("no_done_after_abort", bad, 0);
    sweep(4, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
